// File: rtl/aes_key_expand_if.sv
// Round-key bus between the key schedule and its controller / aes_addroundkey.
// AES_KEYEXP_REWIND_EN adds the rewind request line.
interface aes_key_expand_if;
    logic         ld;
    logic [127:0] key;
    logic         adv;
`ifdef AES_KEYEXP_REWIND_EN
    logic         rewind;
`endif
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic [3:0]   rnd;
    logic         kvalid;
    logic         last;

`ifdef AES_KEYEXP_REWIND_EN
    modport master (output ld, key, adv, rewind,
                    input  w0, w1, w2, w3, rnd, kvalid, last);
    modport slave  (input  ld, key, adv, rewind,
                    output w0, w1, w2, w3, rnd, kvalid, last);
`else
    modport master (output ld, key, adv,
                    input  w0, w1, w2, w3, rnd, kvalid, last);
    modport slave  (input  ld, key, adv,
                    output w0, w1, w2, w3, rnd, kvalid, last);
`endif
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per advance, round 0 on load.
// AES_KEYEXP_REWIND_EN adds a key shadow and a rewind-to-round-0 request.
module aes_key_expand #(
    parameter int unsigned NR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_key_expand_if.slave kif
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    localparam logic [BYTE_W-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   rk_q, rk_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [BYTE_W-1:0]  rcon_q, rcon_d;
`ifdef AES_KEYEXP_REWIND_EN
    logic [KEY_W-1:0]   shadow_q, shadow_d;
`endif

    logic [WORD_W-1:0]  rot_w, sub_w, t_w;
    logic [WORD_W-1:0]  nw0, nw1, nw2, nw3;
    logic [BYTE_W-1:0]  rcon_nxt;
    logic               run_c;
    logic               last_c;

    // Next round key from the current one: RotWord, SubWord, rcon, then chained XOR.
    always_comb begin
        rot_w    = {rk_q[23:0], rk_q[31:24]};
        sub_w    = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                    SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
        t_w      = sub_w ^ {rcon_q, 24'h000000};
        nw0      = rk_q[127:96] ^ t_w;
        nw1      = rk_q[95:64]  ^ nw0;
        nw2      = rk_q[63:32]  ^ nw1;
        nw3      = rk_q[31:0]   ^ nw2;
        rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        run_c    = (state_q == ST_RUN);
        last_c   = run_c && (rnd_q == RND_W'(NR));
    end

    // Priority: load, then rewind (optional), then advance; stalled once last.
    always_comb begin
        state_d  = state_q;
        rk_d     = rk_q;
        rnd_d    = rnd_q;
        rcon_d   = rcon_q;
`ifdef AES_KEYEXP_REWIND_EN
        shadow_d = shadow_q;
`endif
        if (kif.ld) begin
            state_d  = ST_RUN;
            rk_d     = kif.key;
            rnd_d    = '0;
            rcon_d   = 8'h01;
`ifdef AES_KEYEXP_REWIND_EN
            shadow_d = kif.key;
        end else if (kif.rewind && run_c) begin
            rk_d     = shadow_q;
            rnd_d    = '0;
            rcon_d   = 8'h01;
`endif
        end else if (kif.adv && run_c && !last_c) begin
            rk_d     = {nw0, nw1, nw2, nw3};
            rnd_d    = rnd_q + RND_W'(1);
            rcon_d   = rcon_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rk_q     <= '0;
            rnd_q    <= '0;
            rcon_q   <= 8'h01;
`ifdef AES_KEYEXP_REWIND_EN
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rk_q     <= rk_d;
            rnd_q    <= rnd_d;
            rcon_q   <= rcon_d;
`ifdef AES_KEYEXP_REWIND_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign kif.w0     = rk_q[127:96];
    assign kif.w1     = rk_q[95:64];
    assign kif.w2     = rk_q[63:32];
    assign kif.w3     = rk_q[31:0];
    assign kif.rnd    = rnd_q;
    assign kif.kvalid = run_c;
    assign kif.last   = last_c;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vector table, corner sequences and random traffic
// against a model that expands the full key schedule from a GF(2^8)-derived S-box.
module tb_aes_key_expand;
    localparam int NR = 10;

    logic clk = 1'b0;
    logic rst_n;
    aes_key_expand_if kif ();

    aes_key_expand #(.NR(NR)) dut (.clk(clk), .rst_n(rst_n), .kif(kif));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [256];
    logic [127:0] m_key;
    int           m_rnd;
    bit           m_valid;

    localparam logic [127:0] FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        string        name;
        bit           rn;
        bit           ld;
        logic [127:0] key;
        bit           adv;
        bit           chk;
        logic [127:0] ew;
        logic [3:0]   ernd;
        bit           ekv;
        bit           elast;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Textbook expansion of words w[0..4r+3]; returns round key r.
    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 4 * (r + 1); i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [133:0] dut_out();
        return {kif.w0, kif.w1, kif.w2, kif.w3, kif.rnd, kif.kvalid, kif.last};
    endfunction

    // One clock: drive inputs, update model at the edge, compare 1 time unit later.
    task automatic cyc(input string nm, input bit rn, input bit ld, input logic [127:0] k,
                       input bit adv, input bit rw);
        logic [127:0] ew;
        rst_n   = rn;
        kif.ld  = ld;
        kif.key = k;
        kif.adv = adv;
`ifdef AES_KEYEXP_REWIND_EN
        kif.rewind = rw;
`endif
        @(posedge clk);
        if (!rn) begin
            m_valid = 0; m_rnd = 0;
        end else if (ld) begin
            m_valid = 1; m_rnd = 0; m_key = k;
`ifdef AES_KEYEXP_REWIND_EN
        end else if (rw && m_valid) begin
            m_rnd = 0;
`endif
        end else if (adv && m_valid && m_rnd < NR) begin
            m_rnd++;
        end
        #1;
        ew = m_valid ? round_key(m_key, m_rnd) : 128'h0;
        check(nm, dut_out(), {ew, 4'(m_rnd), m_valid, (m_valid && m_rnd == NR)});
    endtask

    function automatic vec_t mk(input string nm, input bit rn, input bit ld, input bit adv,
                                input bit chk, input logic [127:0] ew, input int er,
                                input bit ekv, input bit el);
        vec_t v;
        v.name = nm; v.rn = rn; v.ld = ld; v.key = FKEY; v.adv = adv; v.chk = chk;
        v.ew = ew; v.ernd = 4'(er); v.ekv = ekv; v.elast = el;
        return v;
    endfunction

    initial begin
        // S-box from multiplicative inverse plus affine map.
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            if (a != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(a));
            end
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[a] = b;
        end
        m_key = '0; m_rnd = 0; m_valid = 0;
        rst_n = 0; kif.ld = 0; kif.key = '0; kif.adv = 0;
`ifdef AES_KEYEXP_REWIND_EN
        kif.rewind = 0;
`endif

        tbl.push_back(mk("reset",        0, 0, 0, 1, 128'h0, 0, 0, 0));
        tbl.push_back(mk("adv_no_key",   1, 0, 1, 1, 128'h0, 0, 0, 0));
        tbl.push_back(mk("load_rk0",     1, 1, 0, 1, FKEY,   0, 1, 0));
        tbl.push_back(mk("adv_rk1",      1, 0, 1, 1, RK1,    1, 1, 0));
        for (int r = 2; r <= 9; r++)
            tbl.push_back(mk($sformatf("adv_rk%0d", r), 1, 0, 1, 0, 128'h0, r, 1, 0));
        tbl.push_back(mk("adv_rk10",     1, 0, 1, 1, RK10,  10, 1, 1));
        tbl.push_back(mk("adv_past_nr",  1, 0, 1, 1, RK10,  10, 1, 1));
        tbl.push_back(mk("idle_hold",    1, 0, 0, 1, RK10,  10, 1, 1));
        tbl.push_back(mk("ld_with_adv",  1, 1, 1, 1, FKEY,   0, 1, 0));
        for (int r = 1; r <= 5; r++)
            tbl.push_back(mk($sformatf("to_rk%0d", r), 1, 0, 1, r == 1, RK1, r, 1, 0));
        tbl.push_back(mk("reset_mid",    0, 0, 1, 1, 128'h0, 0, 0, 0));
        tbl.push_back(mk("reload",       1, 1, 0, 1, FKEY,   0, 1, 0));
        tbl.push_back(mk("rcon_restart", 1, 0, 1, 1, RK1,    1, 1, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].name, tbl[i].rn, tbl[i].ld, tbl[i].key, tbl[i].adv, 1'b0);
            if (tbl[i].chk)
                check({"vec_", tbl[i].name}, dut_out(),
                      {tbl[i].ew, tbl[i].ernd, tbl[i].ekv, tbl[i].elast});
        end

`ifdef AES_KEYEXP_REWIND_EN
        cyc("rw_load", 1, 1, FKEY, 0, 0);
        for (int r = 1; r <= 7; r++) cyc($sformatf("rw_adv%0d", r), 1, 0, FKEY, 1, 0);
        cyc("rewind", 1, 0, 128'h0, 0, 1);
        check("rewind_lit", dut_out(), {FKEY, 4'd0, 1'b1, 1'b0});
        cyc("rw_adv1", 1, 0, 128'h0, 1, 0);
        check("rw_adv1_lit", dut_out(), {RK1, 4'd1, 1'b1, 1'b0});
        cyc("rw_adv2", 1, 0, 128'h0, 1, 0);
        cyc("rewind_vs_adv", 1, 0, 128'h0, 1, 1);
        check("rewind_vs_adv_lit", dut_out(), {FKEY, 4'd0, 1'b1, 1'b0});
        cyc("rst_shadow", 0, 0, 128'h0, 0, 0);
        cyc("rewind_idle", 1, 0, 128'h0, 0, 1);
        check("rewind_idle_lit", dut_out(), {128'h0, 4'd0, 1'b0, 1'b0});
`endif

        // Random traffic: mostly advances, occasional loads, rewinds and resets.
        for (int n = 0; n < 600; n++) begin
            logic [127:0] rk = {$urandom, $urandom, $urandom, $urandom};
            int p = $urandom_range(0, 99);
            cyc($sformatf("rand%0d", n), p >= 3, p >= 3 && p < 12, rk,
                $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
